// File: rtl/router_pkg.sv
// Shared constants for the 1x3 packet router datapath.
package router_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;

  // Header byte layout: length in [7:2], destination address in [1:0].
  localparam int unsigned LEN_MSB  = 7;
  localparam int unsigned LEN_LSB  = 2;
  localparam int unsigned ADDR_MSB = 1;
  localparam int unsigned ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

  function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr);
    return addr != INVALID_ADDR;
  endfunction

endpackage

// File: rtl/router_reg.sv
// Router datapath register: header latch, byte forwarding to the output FIFO,
// full-FIFO byte parking and running XOR parity check.
module router_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = router_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] header_byte_q, header_byte_d;
  logic [DATA_W-1:0] full_byte_q,   full_byte_d;
  logic [DATA_W-1:0] int_parity_q,  int_parity_d;
  logic [DATA_W-1:0] pkt_parity_q,  pkt_parity_d;
  logic [DATA_W-1:0] dout_q,        dout_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q,         err_d;

  always_comb begin
    header_byte_d   = header_byte_q;
    full_byte_d     = full_byte_q;
    int_parity_d    = int_parity_q;
    pkt_parity_d    = pkt_parity_q;
    dout_d          = dout_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;

    // Address 3 names no output port, so such a header is never latched.
    if (detect_add && pkt_valid && addr_is_valid(data_in[ADDR_MSB:ADDR_LSB]))
      header_byte_d = data_in;

    if (ld_state && fifo_full)
      full_byte_d = data_in;

    if (lfd_state)
      dout_d = header_byte_q;
    else if (ld_state && !fifo_full)
      dout_d = data_in;
    else if (laf_state)
      dout_d = full_byte_q;

    if (detect_add)
      int_parity_d = '0;
    else if (lfd_state)
      int_parity_d = int_parity_q ^ header_byte_q;
    else if (ld_state && pkt_valid && !full_state)
      int_parity_d = int_parity_q ^ data_in;

    if (detect_add)
      pkt_parity_d = '0;
    else if (ld_state && !pkt_valid)
      pkt_parity_d = data_in;

    // Parity byte either goes straight out, or is replayed after a full stall.
    if (detect_add)
      parity_done_d = 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid) ||
             (laf_state && low_pkt_valid_q && !parity_done_q))
      parity_done_d = 1'b1;

    if (rst_int_reg)
      low_pkt_valid_d = 1'b0;
    else if (ld_state && !pkt_valid)
      low_pkt_valid_d = 1'b1;

    if (detect_add)
      err_d = 1'b0;
    else if (parity_done_q)
      err_d = int_parity_q != pkt_parity_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte_q   <= '0;
      full_byte_q     <= '0;
      int_parity_q    <= '0;
      pkt_parity_q    <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      header_byte_q   <= header_byte_d;
      full_byte_q     <= full_byte_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Scoreboard bench for router_reg: packets are driven as FSM control sequences,
// the expected byte stream and parity verdict are queued and checked by a monitor.
module tb_router_reg;

  logic       clock;
  logic       resetn;
  logic       pkt_valid, fifo_full, rst_int_reg, detect_add;
  logic       ld_state, laf_state, full_state, lfd_state;
  logic [7:0] data_in;
  logic       parity_done, low_pkt_valid, err;
  logic [7:0] dout;

  router_reg #(.DATA_W(8)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .fifo_full    (fifo_full),
    .rst_int_reg  (rst_int_reg),
    .detect_add   (detect_add),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .lfd_state    (lfd_state),
    .data_in      (data_in),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err),
    .dout         (dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [7:0] exp_q[$];
  logic       err_q[$];

  logic       mon_en = 1'b0;
  logic       drv_wr = 1'b0;
  logic       wr_q   = 1'b0;
  logic       rst_q  = 1'b0;
  logic [7:0] last_dout = '0;
  logic       pd_prev = 1'b0;
  logic       err_due = 1'b0;

  // Packet description used by send_packet.
  logic [7:0]  pl[0:63];
  logic        stall[0:63];
  int unsigned full_cycles;
  logic        par_stall;
  logic [7:0]  model_hdr = '0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clock) begin
    wr_q  <= drv_wr;
    rst_q <= !resetn;
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (wr_q) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL dout_extra: got %h, required no write", dout);
        end else begin
          check("dout", dout, exp_q.pop_front());
        end
      end else if (!rst_q) begin
        check("dout_hold", dout, last_dout);
      end
      if (parity_done && !pd_prev) begin
        check("low_pkt_valid_at_parity", {7'd0, low_pkt_valid}, 8'd1);
        err_due = 1'b1;
      end else if (err_due) begin
        err_due = 1'b0;
        if (err_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL err_extra: got %b, required no parity verdict", err);
        end else begin
          check("err", {7'd0, err}, {7'd0, err_q.pop_front()});
        end
      end
    end
    last_dout = dout;
    pd_prev   = parity_done;
  end

  task automatic step(input logic da, input logic lfd, input logic ld, input logic laf,
                      input logic fs, input logic ff, input logic pv, input logic ri,
                      input logic [7:0] d, input logic wr);
    detect_add  = da;
    lfd_state   = lfd;
    ld_state    = ld;
    laf_state   = laf;
    full_state  = fs;
    fifo_full   = ff;
    pkt_valid   = pv;
    rst_int_reg = ri;
    data_in     = d;
    drv_wr      = wr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'($urandom), 0);
  endtask

  // Reference view: the FIFO sees last valid header, payload, parity in order;
  // err is set when the XOR of header and payload differs from the parity byte.
  task automatic send_packet(input logic [7:0] hdr, input int unsigned n, input logic bad);
    logic [7:0] acc;
    logic [7:0] par;
    if (hdr[1:0] != 2'b11) model_hdr = hdr;
    acc = model_hdr;
    par = hdr;
    for (int i = 0; i < int'(n); i++) begin
      acc ^= pl[i];
      par ^= pl[i];
    end
    if (bad) par ^= 8'h01;

    step(1, 0, 0, 0, 0, 0, 1, 0, hdr, 0);
    check("parity_done_cleared", {7'd0, parity_done}, 8'd0);
    check("err_cleared", {7'd0, err}, 8'd0);

    exp_q.push_back(model_hdr);
    step(0, 1, 0, 0, 0, 0, 1, 0, pl[0], 1);

    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back(pl[i]);
      if (stall[i]) begin
        step(0, 0, 1, 0, 0, 1, 1, 0, pl[i], 0);
        for (int k = 0; k < int'(full_cycles); k++)
          step(0, 0, 0, 0, 1, 1, 1, 0, 8'($urandom), 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, 8'($urandom), 1);
      end else begin
        step(0, 0, 1, 0, 0, 0, 1, 0, pl[i], 1);
      end
    end

    exp_q.push_back(par);
    err_q.push_back(acc != par);
    if (par_stall) begin
      step(0, 0, 1, 0, 0, 1, 0, 0, par, 0);
      for (int k = 0; k < int'(full_cycles); k++)
        step(0, 0, 0, 0, 1, 1, 0, 0, 8'($urandom), 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom), 1);
    end else begin
      step(0, 0, 1, 0, 0, 0, 0, 0, par, 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'($urandom), 0);
    idle();
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 64; i++) stall[i] = 1'b0;
    par_stall   = 1'b0;
    full_cycles = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    clear_stalls();
    idle();
    check("reset_dout", dout, 8'h00);
    check("reset_parity_done", {7'd0, parity_done}, 8'd0);
    check("reset_low_pkt_valid", {7'd0, low_pkt_valid}, 8'd0);
    check("reset_err", {7'd0, err}, 8'd0);

    // Reset in the middle of a packet after flags have been raised.
    resetn = 1'b1;
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h16, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h5C, 0);
    resetn = 1'b0;
    idle();
    check("midpkt_reset_dout", dout, 8'h00);
    check("midpkt_reset_parity_done", {7'd0, parity_done}, 8'd0);
    check("midpkt_reset_low_pkt_valid", {7'd0, low_pkt_valid}, 8'd0);
    check("midpkt_reset_err", {7'd0, err}, 8'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44; pl[4] = 8'h55;
    send_packet(8'h16, 5, 1'b0);
    send_packet(8'h16, 5, 1'b1);

    pl[2] = 8'hA5;
    stall[2] = 1'b1;
    send_packet(8'h16, 5, 1'b0);
    clear_stalls();

    // Address 3: the previous header (8'h16) is forwarded instead.
    send_packet(8'h17, 5, 1'b0);

    // rst_int_reg clearing low_pkt_valid, including priority over a set.
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h29, 0);
    model_hdr = 8'h29;
    step(0, 0, 1, 0, 0, 1, 0, 1, 8'h3C, 0);
    check("low_pkt_valid_rst_priority", {7'd0, low_pkt_valid}, 8'd0);
    step(0, 0, 1, 0, 0, 1, 0, 0, 8'h3C, 0);
    check("low_pkt_valid_set", {7'd0, low_pkt_valid}, 8'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0);
    check("low_pkt_valid_cleared", {7'd0, low_pkt_valid}, 8'd0);
    idle();

    for (int p = 0; p < 40; p++) begin
      int unsigned len;
      logic [7:0]  hdr;
      len = $urandom_range(1, 8);
      hdr = {6'(len), 2'($urandom_range(0, 3))};
      for (int i = 0; i < int'(len); i++) begin
        pl[i]    = 8'($urandom);
        stall[i] = ($urandom_range(0, 4) == 0);
      end
      par_stall   = ($urandom_range(0, 3) == 0);
      full_cycles = $urandom_range(1, 2);
      send_packet(hdr, len, $urandom_range(0, 2) == 0);
    end

    idle();
    idle();
    check("expected_bytes_left", 8'(exp_q.size()), 8'd0);
    check("expected_verdicts_left", 8'(err_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
